// File: rtl/wb_cmd_master_if.sv
// Bundle of command, response, Wishbone and interrupt signals for wb_cmd_master.
// The master modport is the engine's view; the slave modport is the environment's view.
interface wb_cmd_master_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [DATA_WIDTH-1:0] cmd_dat_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_we_o;
  logic [DATA_WIDTH-1:0] rsp_dat_o;
  logic                  rsp_err_o;
  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  ack_i;
  logic                  irq_i;
  logic                  irq_clr_i;
  logic                  irq_seen_o;
  logic                  busy_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i,
           dat_i, ack_i, irq_i, irq_clr_i,
    output cmd_ready_o, rsp_valid_o, rsp_we_o, rsp_dat_o, rsp_err_o,
           cyc_o, stb_o, we_o, adr_o, dat_o, irq_seen_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i,
           dat_i, ack_i, irq_i, irq_clr_i,
    input  cmd_ready_o, rsp_valid_o, rsp_we_o, rsp_dat_o, rsp_err_o,
           cyc_o, stb_o, we_o, adr_o, dat_o, irq_seen_o, busy_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone command master: FIFO-buffered commands issued as single Wishbone cycles, one
// response per command, sticky interrupt flag. Define WB_CMD_MASTER_TIMEOUT_EN for the ack timeout.
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  wb_cmd_master_if.master bus
);
  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_cmd_master: CMD_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT must be at least 1");
  end

  logic [CMD_W-1:0]      fifo_mem_r [CMD_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  state_t                state_r;
  logic                  cyc_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] adr_r;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  rsp_valid_r;
  logic                  rsp_we_r;
  logic [DATA_WIDTH-1:0] rsp_dat_r;
  logic                  irq_r;
  logic                  irq_seen_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  done_s;
  logic                  abort_s;
  logic [CMD_W-1:0]      head_s;
  logic                  head_we_s;
  logic [ADDR_WIDTH-1:0] head_adr_s;
  logic [DATA_WIDTH-1:0] head_dat_s;

  assign full_s     = (count_r == CNT_W'(CMD_DEPTH));
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign push_s     = bus.cmd_valid_i && !full_s;
  // Launch only when the response slot is free or being emptied on this edge.
  assign pop_s      = (state_r == ST_IDLE) && !empty_s && (!rsp_valid_r || bus.rsp_ready_i);
  assign done_s     = (state_r == ST_REQ) && bus.ack_i;
  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign head_we_s  = head_s[CMD_W-1];
  assign head_adr_s = head_s[DATA_WIDTH +: ADDR_WIDTH];
  assign head_dat_s = head_s[DATA_WIDTH-1:0];

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] to_cnt_r;
  logic            rsp_err_r;
  assign abort_s       = (state_r == ST_REQ) && !bus.ack_i && (to_cnt_r == TO_W'(TIMEOUT - 1));
  assign bus.rsp_err_o = rsp_err_r;
`else
  assign abort_s       = 1'b0;
  assign bus.rsp_err_o = 1'b0;
`endif

  // Command storage; occupancy is tracked by the pointers so the array needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {bus.cmd_we_i, bus.cmd_adr_i, bus.cmd_dat_i};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Bus FSM with registered Wishbone controls and the response slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= {ADDR_WIDTH{1'b0}};
      dat_r       <= {DATA_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_dat_r   <= {DATA_WIDTH{1'b0}};
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      to_cnt_r    <= {TO_W{1'b0}};
      rsp_err_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            state_r <= ST_REQ;
            cyc_r   <= 1'b1;
            we_r    <= head_we_s;
            adr_r   <= head_adr_s;
            dat_r   <= head_we_s ? head_dat_s : {DATA_WIDTH{1'b0}};
          end
        end
        ST_REQ: begin
          if (done_s || abort_s) begin
            state_r <= ST_IDLE;
            cyc_r   <= 1'b0;
            we_r    <= 1'b0;
            adr_r   <= {ADDR_WIDTH{1'b0}};
            dat_r   <= {DATA_WIDTH{1'b0}};
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            to_cnt_r <= {TO_W{1'b0}};
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
`endif
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cyc_r   <= 1'b0;
        end
      endcase

      // A new response overrides the clear when both happen on one edge.
      if (done_s || abort_s) begin
        rsp_valid_r <= 1'b1;
        rsp_we_r    <= we_r;
        rsp_dat_r   <= (done_s && !we_r) ? bus.dat_i : {DATA_WIDTH{1'b0}};
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        rsp_err_r   <= abort_s;
`endif
      end else if (rsp_valid_r && bus.rsp_ready_i) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  // Interrupt input register and sticky edge flag; a set wins over a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_r      <= 1'b0;
      irq_seen_r <= 1'b0;
    end else begin
      irq_r <= bus.irq_i;
      if (bus.irq_i && !irq_r) begin
        irq_seen_r <= 1'b1;
      end else if (bus.irq_clr_i) begin
        irq_seen_r <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready_o = !full_s && !rst_i;
  assign bus.busy_o      = !empty_s || (state_r == ST_REQ);
  assign bus.cyc_o       = cyc_r;
  assign bus.stb_o       = cyc_r;
  assign bus.we_o        = we_r;
  assign bus.adr_o       = adr_r;
  assign bus.dat_o       = dat_r;
  assign bus.rsp_valid_o = rsp_valid_r;
  assign bus.rsp_we_o    = rsp_we_r;
  assign bus.rsp_dat_o   = rsp_dat_r;
  assign bus.irq_seen_o  = irq_seen_r;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized self-checking bench for wb_cmd_master: a queue-based reference model predicts
// every Wishbone cycle and response; a behavioural slave with per-command wait states answers.
module tb_wb_cmd_master;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct packed { logic we; logic [AW-1:0] adr; logic [DW-1:0] dat; } bus_txn_t;
  typedef struct packed { logic we; logic [DW-1:0] dat; logic err; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state: expected bus cycles, their wait states, expected responses.
  bus_txn_t     exp_bus[$];
  int           exp_ws[$];
  rsp_t         exp_rsp[$];
  int           gap_q[$];
  logic [DW-1:0] model_mem [4];
  logic [DW-1:0] slv_mem [4];
  int           n_exp_rsp = 0;

  // Environment (slave + monitor + response sink) state.
  logic     in_txn  = 1'b0;
  int       txn_ws  = 0;
  int       txn_len = 0;
  int       low_len = 0;
  bus_txn_t cur;
  int       bus_cnt = 0;
  int       rsp_cnt = 0;
  int       rdy_mode = 1;

  initial begin
    logic rr;
    rsp_t r;
    bus.ack_i       = 1'b0;
    bus.dat_i       = '0;
    bus.rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       rr = 1'b0;
        1:       rr = 1'b1;
        default: rr = ($urandom_range(0, 1) != 0);
      endcase
      bus.rsp_ready_i = rr;
      if (bus.rsp_valid_o === 1'b1 && rr) begin
        if (exp_rsp.size() == 0) begin
          check_eq("rsp_unexp", 32'(bus.rsp_valid_o), 32'd0);
        end else begin
          r = exp_rsp.pop_front();
          check_eq("rsp_we", 32'(bus.rsp_we_o), 32'(r.we));
          check_eq("rsp_dat", 32'(bus.rsp_dat_o), 32'(r.dat));
          check_eq("rsp_err", 32'(bus.rsp_err_o), 32'(r.err));
          rsp_cnt++;
        end
      end
      if (bus.cyc_o === 1'b1 && !in_txn) begin
        in_txn  = 1'b1;
        txn_len = 1;
        gap_q.push_back(low_len);
        bus_cnt++;
        if (exp_bus.size() == 0) begin
          check_eq("bus_unexp", 32'(bus.cyc_o), 32'd0);
          cur    = '{bus.we_o, bus.adr_o, bus.dat_o};
          txn_ws = 0;
        end else begin
          cur    = exp_bus.pop_front();
          txn_ws = exp_ws.pop_front();
          check_eq("bus_start", 32'({bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o}),
                   32'({1'b1, cur.we, cur.adr, cur.dat}));
        end
      end else if (bus.cyc_o === 1'b1) begin
        txn_len++;
        check_eq("bus_stable", 32'({bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o}),
                 32'({1'b1, cur.we, cur.adr, cur.dat}));
      end else if (in_txn) begin
        in_txn  = 1'b0;
        low_len = 1;
        check_eq("bus_len", 32'(txn_len), 32'((txn_ws < 0) ? TMO : txn_ws + 1));
        check_eq("bus_idle", 32'({bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o}), 32'd0);
      end else begin
        low_len++;
      end
      // Slave: acknowledge after the command's wait states; a negative count never acks.
      if (bus.cyc_o === 1'b1 && txn_ws >= 0 && txn_len == txn_ws + 1) begin
        bus.ack_i = 1'b1;
        if (bus.we_o) begin
          slv_mem[bus.adr_o] = bus.dat_o;
          bus.dat_i = DW'($urandom);
        end else begin
          bus.dat_i = slv_mem[bus.adr_o];
        end
      end else begin
        bus.ack_i = 1'b0;
        bus.dat_i = DW'($urandom);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input int ws);
    logic ok;
    ok = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      ok = bus.cmd_ready_o;
      tick();
    end
    bus.cmd_valid_i = 1'b0;
    if (!ok) begin
      check_eq("push_timeout", 32'(ok), 32'd1);
    end else begin
      exp_bus.push_back('{we, adr, we ? dat : {DW{1'b0}}});
      exp_ws.push_back(ws);
      n_exp_rsp++;
      if (ws < 0) begin
        exp_rsp.push_back('{we, {DW{1'b0}}, 1'b1});
      end else if (we) begin
        model_mem[adr] = dat;
        exp_rsp.push_back('{1'b1, {DW{1'b0}}, 1'b0});
      end else begin
        exp_rsp.push_back('{1'b0, model_mem[adr], 1'b0});
      end
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int t;
    t = 0;
    while ((exp_rsp.size() != 0 || bus.busy_o) && t < max_cycles) begin
      tick();
      t++;
    end
    if (t >= max_cycles) check_eq("drain_timeout", 32'(exp_rsp.size()), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    int base;
    int ws;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.irq_i       = 1'b0;
    bus.irq_clr_i   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slv_mem[i]   = DW'($urandom);
      model_mem[i] = slv_mem[i];
    end

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check_eq("rdy_in_rst", 32'(bus.cmd_ready_o), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_outs", 32'({bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o,
                              bus.rsp_valid_o, bus.rsp_we_o, bus.rsp_dat_o, bus.rsp_err_o,
                              bus.irq_seen_o, bus.busy_o}), 32'd0);
    check_eq("rst_rdy", 32'(bus.cmd_ready_o), 32'd1);
    tick();

    // Zero-wait write: latency and single-cycle bus occupancy.
    push_cmd(1'b1, 2'd2, 8'h5A, 0);
    @(negedge clk);
    check_eq("lat_n", 32'(bus.cyc_o), 32'd0);
    @(negedge clk);
    check_eq("lat_n1", 32'({bus.cyc_o, bus.we_o, bus.dat_o}), 32'({1'b1, 1'b1, 8'h5A}));
    @(negedge clk);
    check_eq("ack_drop", 32'({bus.cyc_o, bus.rsp_valid_o}), 32'({1'b0, 1'b1}));
    tick();
    wait_drain(200);

    // Read with 3 wait states returning previously written 0xC3.
    push_cmd(1'b1, 2'd1, 8'hC3, 1);
    push_cmd(1'b0, 2'd1, 8'hFF, 3);
    wait_drain(200);

    // Fill the FIFO while responses are blocked, then drain.
    rdy_mode = 0;
    base = bus_cnt;
    for (int i = 0; i < 5; i++) push_cmd(1'(i & 1), AW'(i), DW'(8'h10 + i), 0);
    @(negedge clk);
    check_eq("full_rdy", 32'(bus.cmd_ready_o), 32'd0);
    check_eq("full_one_txn", 32'(bus_cnt - base), 32'd1);
    check_eq("full_busy", 32'(bus.busy_o), 32'd1);
    tick();
    gap_q.delete();
    rdy_mode = 1;
    wait_drain(300);
    check_eq("gap_cnt", 32'(gap_q.size()), 32'd4);
    for (int i = 1; i < gap_q.size(); i++) check_eq("gap_one", 32'(gap_q[i]), 32'd1);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // Slave never acks: abort after TMO cycles, then a normal command.
    push_cmd(1'b0, 2'd3, 8'h00, -1);
    push_cmd(1'b1, 2'd0, 8'h11, 0);
    wait_drain(300);
`endif

    // Reset during a stalled cycle with two commands queued.
    base = rsp_cnt;
    push_cmd(1'b0, 2'd0, 8'h00, 12);
    for (int t = 0; t < 20 && bus.cyc_o !== 1'b1; t++) tick();
    push_cmd(1'b1, 2'd1, 8'h33, 0);
    push_cmd(1'b0, 2'd2, 8'h00, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rdy_in_rst2", 32'(bus.cmd_ready_o), 32'd0);
    tick();
    rst = 1'b0;
    exp_bus.delete();
    exp_ws.delete();
    n_exp_rsp -= exp_rsp.size();
    exp_rsp.delete();
    in_txn  = 1'b0;
    low_len = 0;
    for (int i = 0; i < 4; i++) model_mem[i] = slv_mem[i];
    @(negedge clk);
    check_eq("rst_req", 32'({bus.cyc_o, bus.stb_o, bus.busy_o, bus.rsp_valid_o}), 32'd0);
    check_eq("rst_req_rdy", 32'(bus.cmd_ready_o), 32'd1);
    repeat (20) tick();
    check_eq("rst_no_rsp", 32'(rsp_cnt - base), 32'd0);

    // Interrupt: set, simultaneous set/clear, clear, held level.
    check_eq("irq_init", 32'(bus.irq_seen_o), 32'd0);
    bus.irq_i = 1'b1;
    tick();
    bus.irq_i = 1'b0;
    check_eq("irq_set", 32'(bus.irq_seen_o), 32'd1);
    tick();
    bus.irq_i     = 1'b1;
    bus.irq_clr_i = 1'b1;
    tick();
    bus.irq_clr_i = 1'b0;
    check_eq("irq_set_clr", 32'(bus.irq_seen_o), 32'd1);
    tick();
    check_eq("irq_hold", 32'(bus.irq_seen_o), 32'd1);
    bus.irq_clr_i = 1'b1;
    tick();
    bus.irq_clr_i = 1'b0;
    check_eq("irq_clr", 32'(bus.irq_seen_o), 32'd0);
    tick();
    check_eq("irq_level", 32'(bus.irq_seen_o), 32'd0);
    bus.irq_i = 1'b0;

    // Random traffic with random wait states and random response back-pressure.
    rdy_mode = 2;
    for (int n = 0; n < 80; n++) begin
      ws = int'($urandom_range(0, 4));
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      if ($urandom_range(0, 9) == 0) ws = -1;
`endif
      push_cmd(($urandom_range(0, 1) != 0), AW'($urandom), DW'($urandom), ws);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain(5000);
    check_eq("rsp_count", 32'(rsp_cnt), 32'(n_exp_rsp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
